river_crossing_ctrl: RTL and testbench
======================================

Name: river_crossing_ctrl

Overview:
Sequential game controller for the farmer/cabbage/goat/wolf river-crossing puzzle. It accepts move requests through a valid/ready handshake and models a multi-cycle crossing. It owns and drives the four bank-position bits (0 = near bank, 1 = far bank), checks for loss using the same unsafe-bank rule as the alarm checker, and detects the win.

Parameters:
CROSS_CYCLES, 4, cycles a crossing takes from accept to position update; legal range >= 1.
COUNT_W, 5, width of the move counter.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
new_game  input  1  synchronous restart request; highest priority after reset.
move_valid  input  1  move request present.
move_sel  input  2  passenger select: 00 farmer alone, 01 cabbage, 10 goat, 11 wolf.
move_ready  output  1  controller can accept a move this cycle.
farmer  output  1  farmer position.
cabbage  output  1  cabbage position.
goat  output  1  goat position.
wolf  output  1  wolf position.
illegal  output  1  one-cycle pulse when a move is rejected.
win  output  1  high in the WIN state.
lose  output  1  high in the LOSE state.
move_count  output  COUNT_W  number of completed crossings.

Behaviour:
- Decided: one clock, clk; reset is asynchronous and active-high, named reset.
- Reset (async, immediate): all positions 0, move_count 0, illegal 0, win 0, lose 0, state PLAY, move_ready 1, crossing timer 0.
- States: PLAY, CROSS, WIN, LOSE. move_ready = (state == PLAY).
- Accept: a move is accepted when move_valid && move_ready at a rising edge. When move_ready is 0, move_valid is ignored and illegal is not pulsed.
- Legality check on accept: move_sel 00 is always legal. Otherwise the move is legal only if the selected item's position equals farmer.
- Illegal accept: illegal = 1 for exactly the next cycle. State stays PLAY, and positions and move_count do not change.
- Legal accept: state becomes CROSS, the timer loads CROSS_CYCLES-1, and the passenger is latched. Positions hold during CROSS.
- In CROSS, the timer decrements each cycle. On the edge where the timer is 0:
  - farmer and the latched passenger toggle on the same edge;
  - move_count increments, saturating at 2^COUNT_W-1;
  - the next state is taken from the new positions: WIN if all four are 1; else LOSE if unsafe; else PLAY.
- Timing: a legal accept at edge E updates the positions at edge E+CROSS_CYCLES. move_ready is low from E until that update edge, and returns high on it if the next state is PLAY.
- Unsafe rule (same as the alarm checker): (goat == cabbage && goat != farmer) || (goat == wolf && goat != farmer).
- WIN and LOSE are terminal. move_ready is 0 and positions and count hold; only new_game or reset leaves these states.
- new_game: at the next edge, returns every output to its reset value from any state, including mid-CROSS (the crossing is aborted and no toggle occurs). new_game beats a simultaneous move accept.
- win and lose are never both 1, and illegal is never 1 outside PLAY's following cycle.

Test Plan:
- Win path, CROSS_CYCLES=1: moves goat, alone, wolf, goat, cabbage, alone, goat -> after the 7th update, positions 1111, win=1, lose=0, move_count=7, move_ready=0.
- Loss: from reset, move_sel=00 -> positions farmer=1, others 0; lose=1, move_count=1, move_ready=0.
- Illegal: after a goat crossing (positions 1010), request cabbage -> illegal high for 1 cycle; positions stay 1010, move_count stays 1, move_ready stays 1.
- Latency, CROSS_CYCLES=4: goat accepted at edge 0 -> move_ready low for edges 0..3; positions 0000 through edge 3, 1010 at edge 4; move_valid held during CROSS is ignored.
- Abort and reset: new_game at cycle 2 of a crossing -> positions stay 0000, count 0, PLAY at the next edge. Asynchronous reset asserted mid-crossing -> all outputs 0 and move_ready 1 before the next clock edge.
- Saturation, COUNT_W=3: 10 goat-only round-trip moves (1010 / 0000, all safe) -> move_count reaches 7 and holds at 7; no lose or illegal.

Source files
------------

// File: rtl/river_crossing_ctrl.sv
// River-crossing puzzle controller: accepts farmer moves, times the crossing, then judges win/lose.
// Latency: a legal move updates the positions CROSS_CYCLES edges after the accept edge; an illegal move pulses illegal on the next cycle.
// Backpressure: move_ready is high only in PLAY; move_valid is ignored while crossing or after the game has ended.
module river_crossing_ctrl #(
    parameter int CROSS_CYCLES = 4,
    parameter int COUNT_W      = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               new_game,
    input  logic               move_valid,
    input  logic [1:0]         move_sel,
    output logic               move_ready,
    output logic               farmer,
    output logic               cabbage,
    output logic               goat,
    output logic               wolf,
    output logic               illegal,
    output logic               win,
    output logic               lose,
    output logic [COUNT_W-1:0] move_count
);

    localparam int TW = (CROSS_CYCLES > 1) ? $clog2(CROSS_CYCLES) : 1;
    localparam logic [TW-1:0]      TIMER_LOAD = TW'(CROSS_CYCLES - 1);
    localparam logic [COUNT_W-1:0] COUNT_MAX  = '1;

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        CROSS = 2'd1,
        WIN   = 2'd2,
        LOSE  = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [TW-1:0]      timer, timer_nxt;
    logic [1:0]         passenger, passenger_nxt;
    logic               farmer_nxt, cabbage_nxt, goat_nxt, wolf_nxt;
    logic [COUNT_W-1:0] count_nxt;
    logic               illegal_nxt;

    // Position of the requested passenger; "farmer alone" compares the farmer
    // with himself so it is always legal.
    logic item_pos;
    logic legal;
    // Positions as they will be once the current crossing lands.
    logic f_new, c_new, g_new, w_new;
    logic unsafe_new;

    assign move_ready = (state == PLAY);
    assign win        = (state == WIN);
    assign lose       = (state == LOSE);

    // Legality of the requested move and the landing positions of the crossing in flight.
    always_comb begin
        item_pos = farmer;
        case (move_sel)
            2'b01:   item_pos = cabbage;
            2'b10:   item_pos = goat;
            2'b11:   item_pos = wolf;
            default: item_pos = farmer;
        endcase
        legal = (item_pos == farmer);

        f_new = ~farmer;
        c_new = cabbage ^ (passenger == 2'b01);
        g_new = goat    ^ (passenger == 2'b10);
        w_new = wolf    ^ (passenger == 2'b11);
        unsafe_new = ((g_new == c_new) && (g_new != f_new)) ||
                     ((g_new == w_new) && (g_new != f_new));
    end

    // Next-state and next-datapath logic; new_game overrides everything else.
    always_comb begin
        state_nxt     = state;
        timer_nxt     = timer;
        passenger_nxt = passenger;
        farmer_nxt    = farmer;
        cabbage_nxt   = cabbage;
        goat_nxt      = goat;
        wolf_nxt      = wolf;
        count_nxt     = move_count;
        illegal_nxt   = 1'b0;

        if (new_game) begin
            state_nxt     = PLAY;
            timer_nxt     = '0;
            passenger_nxt = 2'b00;
            farmer_nxt    = 1'b0;
            cabbage_nxt   = 1'b0;
            goat_nxt      = 1'b0;
            wolf_nxt      = 1'b0;
            count_nxt     = '0;
        end else begin
            case (state)
                PLAY: begin
                    if (move_valid) begin
                        if (legal) begin
                            state_nxt     = CROSS;
                            timer_nxt     = TIMER_LOAD;
                            passenger_nxt = move_sel;
                        end else begin
                            illegal_nxt = 1'b1;
                        end
                    end
                end
                CROSS: begin
                    if (timer == '0) begin
                        farmer_nxt  = f_new;
                        cabbage_nxt = c_new;
                        goat_nxt    = g_new;
                        wolf_nxt    = w_new;
                        if (move_count != COUNT_MAX) begin
                            count_nxt = move_count + COUNT_W'(1);
                        end
                        if (f_new && c_new && g_new && w_new) begin
                            state_nxt = WIN;
                        end else if (unsafe_new) begin
                            state_nxt = LOSE;
                        end else begin
                            state_nxt = PLAY;
                        end
                    end else begin
                        timer_nxt = timer - TW'(1);
                    end
                end
                WIN, LOSE: begin
                    state_nxt = state;
                end
                default: begin
                    state_nxt = PLAY;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= PLAY;
        end else begin
            state <= state_nxt;
        end
    end

    // Positions, counter, timer, latched passenger and the illegal pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer      <= '0;
            passenger  <= 2'b00;
            farmer     <= 1'b0;
            cabbage    <= 1'b0;
            goat       <= 1'b0;
            wolf       <= 1'b0;
            move_count <= '0;
            illegal    <= 1'b0;
        end else begin
            timer      <= timer_nxt;
            passenger  <= passenger_nxt;
            farmer     <= farmer_nxt;
            cabbage    <= cabbage_nxt;
            goat       <= goat_nxt;
            wolf       <= wolf_nxt;
            move_count <= count_nxt;
            illegal    <= illegal_nxt;
        end
    end

endmodule

// File: tb/tb_river_crossing_ctrl.sv
// Bench for river_crossing_ctrl: instance A (4-cycle crossing, 5-bit count), instance B (1-cycle crossing, 3-bit count).
// A position-based game model predicts every output each cycle; directed literal checks pin the model.
// Inputs change on the falling edge, outputs are compared on the falling edge.
module tb_river_crossing_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       a_new, a_valid, b_new, b_valid;
    logic [1:0] a_sel, b_sel;
    logic       a_ready, a_f, a_c, a_g, a_w, a_ill, a_win, a_lose;
    logic       b_ready, b_f, b_c, b_g, b_w, b_ill, b_win, b_lose;
    logic [4:0] a_count;
    logic [2:0] b_count;

    river_crossing_ctrl #(.CROSS_CYCLES(4), .COUNT_W(5)) dut_a (
        .clk(clk), .reset(reset), .new_game(a_new), .move_valid(a_valid), .move_sel(a_sel),
        .move_ready(a_ready), .farmer(a_f), .cabbage(a_c), .goat(a_g), .wolf(a_w),
        .illegal(a_ill), .win(a_win), .lose(a_lose), .move_count(a_count));

    river_crossing_ctrl #(.CROSS_CYCLES(1), .COUNT_W(3)) dut_b (
        .clk(clk), .reset(reset), .new_game(b_new), .move_valid(b_valid), .move_sel(b_sel),
        .move_ready(b_ready), .farmer(b_f), .cabbage(b_c), .goat(b_g), .wolf(b_w),
        .illegal(b_ill), .win(b_win), .lose(b_lose), .move_count(b_count));

    // Output vector layout: {ready, farmer, cabbage, goat, wolf, illegal, win, lose, count[7:0]}
    logic [15:0] a_vec, b_vec;
    assign a_vec = {a_ready, a_f, a_c, a_g, a_w, a_ill, a_win, a_lose, 3'b000, a_count};
    assign b_vec = {b_ready, b_f, b_c, b_g, b_w, b_ill, b_win, b_lose, 5'b00000, b_count};

    // Game model: pos[3]=farmer, [2]=cabbage, [1]=goat, [0]=wolf.
    // left = edges until the crossing in flight lands (0 = none in flight).
    typedef struct {
        logic [3:0] pos;
        int         left;
        logic [1:0] pass;
        int         cnt;
        logic       ill;
    } mdl_t;

    mdl_t ma, mb;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   started  = 1'b0;

    function automatic mdl_t m_reset();
        mdl_t m;
        m.pos  = 4'b0000;
        m.left = 0;
        m.pass = 2'b00;
        m.cnt  = 0;
        m.ill  = 1'b0;
        return m;
    endfunction

    function automatic logic unsafe4(logic [3:0] p);
        return ((p[1] == p[2]) && (p[1] != p[3])) || ((p[1] == p[0]) && (p[1] != p[3]));
    endfunction

    function automatic logic m_over(mdl_t m);
        return (m.pos == 4'b1111) || unsafe4(m.pos);
    endfunction

    function automatic logic m_ready(mdl_t m);
        return (m.left == 0) && !m_over(m);
    endfunction

    function automatic mdl_t m_step(mdl_t m, logic ng, logic v, logic [1:0] sel, int cc, int cw);
        mdl_t n;
        int   idx;
        n = m;
        n.ill = 1'b0;
        if (ng) return m_reset();
        if (m.left > 0) begin
            n.left = m.left - 1;
            if (n.left == 0) begin
                n.pos[3] = ~m.pos[3];
                if (m.pass != 2'b00) begin
                    idx = 3 - int'(m.pass);
                    n.pos[idx] = ~m.pos[idx];
                end
                if (m.cnt < (1 << cw) - 1) n.cnt = m.cnt + 1;
            end
        end else if (m_ready(m) && v) begin
            idx = 3 - int'(sel);
            if (m.pos[idx] == m.pos[3]) begin
                n.left = cc;
                n.pass = sel;
            end else begin
                n.ill = 1'b1;
            end
        end
        return n;
    endfunction

    function automatic logic [15:0] m_out(mdl_t m);
        logic [7:0] c;
        c = 8'(m.cnt);
        return {m_ready(m), m.pos, m.ill, (m.pos == 4'b1111), unsafe4(m.pos), c};
    endfunction

    // Model advances on every edge using the inputs that were set on the previous falling edge.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ma = m_reset();
            mb = m_reset();
        end else begin
            ma = m_step(ma, a_new, a_valid, a_sel, 4, 5);
            mb = m_step(mb, b_new, b_valid, b_sel, 1, 3);
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("a_cycle", a_vec, m_out(ma));
            chk("b_cycle", b_vec, m_out(mb));
        end
    end

    function automatic logic rdy(int i);
        return (i == 0) ? a_ready : b_ready;
    endfunction

    function automatic logic done(int i);
        return (i == 0) ? (a_ready || a_win || a_lose) : (b_ready || b_win || b_lose);
    endfunction

    task automatic set_in(int i, logic ng, logic v, logic [1:0] s);
        if (i == 0) begin a_new = ng; a_valid = v; a_sel = s; end
        else        begin b_new = ng; b_valid = v; b_sel = s; end
    endtask

    task automatic new_game(int i);
        @(negedge clk);
        set_in(i, 1'b1, 1'b0, 2'b00);
        @(negedge clk);
        set_in(i, 1'b0, 1'b0, 2'b00);
    endtask

    // Presents one move; returns on the falling edge right after the accept edge.
    task automatic do_move(int i, logic [1:0] s);
        int k;
        k = 0;
        while (!rdy(i) && k < 64) begin @(negedge clk); k++; end
        if (!rdy(i)) timeout_fail("move_wait");
        set_in(i, 1'b0, 1'b1, s);
        @(negedge clk);
        set_in(i, 1'b0, 1'b0, 2'b00);
    endtask

    task automatic settle(int i);
        int k;
        k = 0;
        while (!done(i) && k < 64) begin @(negedge clk); k++; end
        if (!done(i)) timeout_fail("settle_wait");
    endtask

    task automatic move_settle(int i, logic [1:0] s);
        do_move(i, s);
        settle(i);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [1:0] win_seq [7];
        ma = m_reset();
        mb = m_reset();
        reset = 1'b1;
        set_in(0, 1'b0, 1'b0, 2'b00);
        set_in(1, 1'b0, 1'b0, 2'b00);
        #2;
        chk("reset_a", a_vec, {1'b1, 4'b0000, 3'b000, 8'd0});
        chk("reset_b", b_vec, {1'b1, 4'b0000, 3'b000, 8'd0});
        @(negedge clk);
        reset = 1'b0;
        started = 1'b1;

        // Latency on A: goat accepted at edge 0, valid held through the crossing.
        set_in(0, 1'b0, 1'b1, 2'b10);
        for (int e = 0; e < 4; e++) begin
            @(negedge clk);
            chk("lat_cross", a_vec, {1'b0, 4'b0000, 3'b000, 8'd0});
            if (e == 3) set_in(0, 1'b0, 1'b0, 2'b00);
        end
        @(negedge clk);
        chk("lat_land", a_vec, {1'b1, 4'b1010, 3'b000, 8'd1});

        // Illegal on A: cabbage requested while it sits away from the farmer.
        do_move(0, 2'b01);
        chk("illegal_pulse", a_vec, {1'b1, 4'b1010, 3'b100, 8'd1});
        @(negedge clk);
        chk("illegal_clear", a_vec, {1'b1, 4'b1010, 3'b000, 8'd1});

        // Loss on A: farmer leaves alone from the start.
        new_game(0);
        chk("newgame_a", a_vec, {1'b1, 4'b0000, 3'b000, 8'd0});
        move_settle(0, 2'b00);
        chk("loss", a_vec, {1'b0, 4'b1000, 3'b001, 8'd1});
        repeat (3) @(negedge clk);
        chk("loss_hold", a_vec, {1'b0, 4'b1000, 3'b001, 8'd1});

        // Abort on A: new_game during the crossing.
        new_game(0);
        do_move(0, 2'b10);
        @(negedge clk);
        set_in(0, 1'b1, 1'b0, 2'b00);
        @(negedge clk);
        set_in(0, 1'b0, 1'b0, 2'b00);
        chk("abort", a_vec, {1'b1, 4'b0000, 3'b000, 8'd0});
        repeat (6) @(negedge clk);
        chk("abort_hold", a_vec, {1'b1, 4'b0000, 3'b000, 8'd0});

        // Win path on B (single-cycle crossing).
        win_seq = '{2'b10, 2'b00, 2'b11, 2'b10, 2'b01, 2'b00, 2'b10};
        for (int m = 0; m < 7; m++) move_settle(1, win_seq[m]);
        chk("win", b_vec, {1'b0, 4'b1111, 3'b010, 8'd7});

        // Saturation on B: ten goat round-trip moves with a 3-bit counter.
        new_game(1);
        for (int m = 0; m < 10; m++) move_settle(1, 2'b10);
        chk("saturate", b_vec, {1'b1, 4'b0000, 3'b000, 8'd7});

        // Asynchronous reset in the middle of a crossing on A.
        do_move(0, 2'b10);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("async_reset_a", a_vec, {1'b1, 4'b0000, 3'b000, 8'd0});
        chk("async_reset_b", b_vec, {1'b1, 4'b0000, 3'b000, 8'd0});
        #1 reset = 1'b0;

        // Randomized play on both instances against the model.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            if (m_over(ma)) set_in(0, ($urandom_range(0, 3) == 0), 1'b0, 2'b00);
            else set_in(0, ($urandom_range(0, 99) < 2), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            if (m_over(mb)) set_in(1, ($urandom_range(0, 3) == 0), 1'b0, 2'b00);
            else set_in(1, ($urandom_range(0, 99) < 2), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        end
        @(negedge clk);
        set_in(0, 1'b0, 1'b0, 2'b00);
        set_in(1, 1'b0, 1'b0, 2'b00);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
